// File: rtl/dma_pkg.sv
// Shared types and bus codes for the system-bus DMA controller.
// Imported by the arbiter and the controller top.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        NEXT,
        RELEASE
    } state_t;

    localparam logic [3:0] CB_READ_CODE  = 4'b1010;
    localparam logic [3:0] CB_WRITE_CODE = 4'b1001;

    localparam logic [1:0] REG_SRC   = 2'd0;
    localparam logic [1:0] REG_DST   = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_SRC_INC = 1;
    localparam int CTRL_DST_INC = 2;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_bus_controller_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at ptr and
// wraps, so the channel served last has lowest priority next time.
module dma_rr_arbiter
    import dma_pkg::*;
#(
    parameter int NCH = 2,
    localparam int CW = idx_w(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    output logic [NCH-1:0] grant,
    output logic [CW-1:0]  idx,
    output logic           valid
);

    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            c = (int'(ptr) + k) % NCH;
            for (int j = 0; j < NCH; j++) begin
                if (j == c && req[j] && !valid) begin
                    valid    = 1'b1;
                    grant[j] = 1'b1;
                    idx      = CW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/dma_bus_controller.sv
// Memory-to-memory DMA bus master; takes the shared bus from the
// CPU with HLDR/HLDA and moves one byte per READ/WRITE/NEXT triple.
module dma_bus_controller
    import dma_pkg::*;
#(
    parameter int          NCH      = 2,
    parameter int          AW       = 8,
    parameter int          DW       = 8,
    parameter logic [3:0]  CB_READ  = CB_READ_CODE,
    parameter logic [3:0]  CB_WRITE = CB_WRITE_CODE,
    localparam int         CW       = idx_w(NCH)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           cfg_we,
    input  logic [CW-1:0]  cfg_ch,
    input  logic [1:0]     cfg_reg,
    input  logic [DW-1:0]  cfg_wdata,
    input  logic [NCH-1:0] dreq,
    output logic [NCH-1:0] dack,
    output logic           HLDR,
    input  logic           HLDA,
    output logic [AW-1:0]  AB_out,
    output logic           AB_oe,
    output logic [DW-1:0]  DB_out,
    output logic           DB_oe,
    input  logic [DW-1:0]  DB_in,
    output logic [3:0]     CB_out,
    output logic           CB_oe,
    output logic [NCH-1:0] done,
    output logic           irq
);

    state_t state, state_n;

    logic [AW-1:0]  src  [NCH];
    logic [AW-1:0]  dst  [NCH];
    logic [DW-1:0]  cnt  [NCH];
    logic [2:0]     ctrl [NCH];

    logic [CW-1:0]  cur;
    logic [NCH-1:0] cur_oh;
    logic [CW-1:0]  rr;
    logic [DW-1:0]  data;
    logic [NCH-1:0] done_q;

    logic [NCH-1:0] elig;
    logic [NCH-1:0] grant;
    logic [CW-1:0]  gidx;
    logic           gvalid;
    logic           last;
    logic           busy;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            elig[i] = ctrl[i][CTRL_EN] && (cnt[i] != '0) && dreq[i];
        end
    end

    dma_rr_arbiter #(.NCH(NCH)) u_arb (
        .req   (elig),
        .ptr   (rr),
        .grant (grant),
        .idx   (gidx),
        .valid (gvalid)
    );

    assign last = (cnt[cur] == DW'(1));
    assign busy = state inside {READ, WRITE, NEXT};

    // Losing HLDA anywhere in the byte abandons it and re-requests.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (gvalid) state_n = REQ;
            REQ:     if (HLDA) state_n = READ;
            READ:    state_n = HLDA ? WRITE : REQ;
            WRITE:   state_n = HLDA ? NEXT : REQ;
            NEXT: begin
                if (!HLDA)             state_n = REQ;
                else if (last)         state_n = RELEASE;
                else if (dreq[cur])    state_n = READ;
                else                   state_n = RELEASE;
            end
            RELEASE: if (!HLDA) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        HLDR   = state inside {REQ, READ, WRITE, NEXT};
        AB_oe  = (state inside {READ, WRITE}) && HLDA;
        CB_oe  = AB_oe;
        DB_oe  = (state == WRITE) && HLDA;
        AB_out = '0;
        DB_out = '0;
        CB_out = '0;
        if (state == READ) begin
            AB_out = src[cur];
            CB_out = CB_READ;
        end else if (state == WRITE) begin
            AB_out = dst[cur];
            DB_out = data;
            CB_out = CB_WRITE;
        end
        dack = (busy && HLDA) ? cur_oh : '0;
        done = done_q;
        irq  = |done_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            cur    <= '0;
            cur_oh <= '0;
            rr     <= '0;
            data   <= '0;
            done_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                src[i]  <= '0;
                dst[i]  <= '0;
                cnt[i]  <= '0;
                ctrl[i] <= '0;
            end
        end else begin
            state <= state_n;
            if (state == IDLE && gvalid) begin
                cur    <= gidx;
                cur_oh <= grant;
            end
            if (state == READ && HLDA) data <= DB_in;
            if (state == RELEASE) begin
                rr <= (cur == CW'(NCH - 1)) ? '0 : cur + CW'(1);
            end
            for (int i = 0; i < NCH; i++) begin
                // The channel being served is locked until IDLE.
                if (cfg_we && cfg_ch == CW'(i) &&
                    !(state != IDLE && cur == CW'(i))) begin
                    unique case (cfg_reg)
                        REG_SRC:   src[i] <= AW'(cfg_wdata);
                        REG_DST:   dst[i] <= AW'(cfg_wdata);
                        REG_COUNT: cnt[i] <= cfg_wdata;
                        REG_CTRL: begin
                            ctrl[i]   <= cfg_wdata[2:0];
                            done_q[i] <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                if (state == NEXT && HLDA && cur == CW'(i)) begin
                    cnt[i] <= cnt[i] - DW'(1);
                    src[i] <= src[i] + AW'(ctrl[i][CTRL_SRC_INC]);
                    dst[i] <= dst[i] + AW'(ctrl[i][CTRL_DST_INC]);
                    if (last) begin
                        ctrl[i][CTRL_EN] <= 1'b0;
                        done_q[i]        <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dma_bus_controller.sv
// Scoreboard bench: expected bus cycles are queued by the stimulus
// and popped by a monitor whenever the DMA drives the bus.
module tb_dma_bus_controller;

    logic       clock;
    logic       reset;
    logic       cfg_we;
    logic [0:0] cfg_ch;
    logic [1:0] cfg_reg;
    logic [7:0] cfg_wdata;
    logic [1:0] dreq;
    logic [1:0] dack;
    logic       HLDR;
    logic       HLDA;
    logic [7:0] AB_out;
    logic       AB_oe;
    logic [7:0] DB_out;
    logic       DB_oe;
    logic [7:0] DB_in;
    logic [3:0] CB_out;
    logic       CB_oe;
    logic [1:0] done;
    logic       irq;

    typedef struct {
        bit         wr;
        int         ch;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_t;

    bus_t q[$];
    logic [7:0] mem [256];
    int n_chk = 0;
    int n_fail = 0;
    logic hd1, hd2, drop;

    dma_bus_controller dut (
        .clock(clock), .reset(reset),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_reg(cfg_reg),
        .cfg_wdata(cfg_wdata), .dreq(dreq), .dack(dack),
        .HLDR(HLDR), .HLDA(HLDA),
        .AB_out(AB_out), .AB_oe(AB_oe),
        .DB_out(DB_out), .DB_oe(DB_oe), .DB_in(DB_in),
        .CB_out(CB_out), .CB_oe(CB_oe),
        .done(done), .irq(irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // CPU grants the bus two cycles after HLDR; drop forces it away.
    always @(posedge clock) begin
        #2;
        hd2 = hd1;
        hd1 = HLDR;
    end
    assign HLDA  = hd2 & ~drop;
    assign DB_in = mem[AB_out];

    function automatic logic [7:0] f(input int a);
        return 8'(a * 7 + 3);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clock) begin
        bus_t e;
        if (CB_oe) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL bus_unexpected actual=cb%0h/ab%0h required=none",
                         CB_out, AB_out);
            end else begin
                e = q.pop_front();
                chk("bus_cb", 32'(CB_out), e.wr ? 32'hA - 32'h1 : 32'hA);
                chk("bus_ab", 32'(AB_out), 32'(e.addr));
                chk("bus_dack", 32'(dack), 32'(1 << e.ch));
                chk("bus_db_oe", 32'(DB_oe), 32'(e.wr));
                if (e.wr) chk("bus_db", 32'(DB_out), 32'(e.data));
            end
            if (CB_out == 4'b1001 && DB_oe) mem[AB_out] = DB_out;
        end
    end

    task automatic push_rd(input int ch, input int a);
        q.push_back('{1'b0, ch, 8'(a), 8'h00});
    endtask

    task automatic push_wr(input int ch, input int a, input int d);
        q.push_back('{1'b1, ch, 8'(a), 8'(d)});
    endtask

    task automatic cfg(input int ch, input int r, input int v);
        @(negedge clock);
        cfg_we    = 1'b1;
        cfg_ch    = 1'(ch);
        cfg_reg   = 2'(r);
        cfg_wdata = 8'(v);
        @(negedge clock);
        cfg_we    = 1'b0;
    endtask

    task automatic setup(input int ch, input int s, input int d,
                         input int c, input int ct);
        cfg(ch, 0, s);
        cfg(ch, 1, d);
        cfg(ch, 2, c);
        cfg(ch, 3, ct);
    endtask

    task automatic wait_done(input int ch);
        int n = 0;
        while (!done[ch] && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk($sformatf("done%0d_wait", ch), 32'(done[ch]), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((HLDR || HLDA) && n < 300) begin
            @(negedge clock);
            n++;
        end
        chk("idle_wait", 32'({HLDR, HLDA}), 32'd0);
        @(negedge clock);
    endtask

    task automatic wait_bus(input logic [3:0] code, input int a);
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!(CB_oe && CB_out == code && AB_out == 8'(a)) && n < 300);
        chk("bus_wait", 32'(CB_oe && CB_out == code && AB_out == 8'(a)), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = f(i);
        hd1 = 1'b0; hd2 = 1'b0; drop = 1'b0;
        reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0;
        cfg_reg = '0; cfg_wdata = '0; dreq = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_hldr", 32'(HLDR), 0);
        chk("rst_dack", 32'(dack), 0);
        chk("rst_done", 32'({done, irq}), 0);
        chk("rst_oe", 32'({AB_oe, DB_oe, CB_oe}), 0);
        chk("rst_out", {AB_out, DB_out, 4'h0, CB_out}, 0);

        // basic 3-byte copy
        setup(0, 10, 40, 3, 7);
        for (int i = 0; i < 3; i++) begin
            push_rd(0, 10 + i);
            push_wr(0, 40 + i, f(10 + i));
        end
        dreq = 2'b01;
        wait_done(0);
        chk("t1_irq", 32'(irq), 1);
        wait_idle();
        dreq = 2'b00;
        for (int i = 0; i < 3; i++)
            chk("t1_mem", 32'(mem[40 + i]), 32'(f(10 + i)));
        cfg(0, 3, 0);
        chk("t1_done_clr", 32'({done, irq}), 0);

        // round robin from reset: 0,1 then 0 alone then 1,0
        @(negedge clock); reset = 1'b1;
        @(negedge clock); reset = 1'b0;
        setup(0, 20, 50, 1, 7);
        setup(1, 30, 60, 1, 7);
        push_rd(0, 20); push_wr(0, 50, f(20));
        push_rd(1, 30); push_wr(1, 60, f(30));
        dreq = 2'b11;
        wait_done(1);
        wait_idle();
        dreq = 2'b00;
        chk("rr_a_done", 32'(done), 3);
        setup(0, 21, 51, 1, 7);
        push_rd(0, 21); push_wr(0, 51, f(21));
        dreq = 2'b01;
        wait_done(0);
        wait_idle();
        dreq = 2'b00;
        setup(0, 22, 52, 1, 7);
        setup(1, 32, 62, 1, 7);
        push_rd(1, 32); push_wr(1, 62, f(32));
        push_rd(0, 22); push_wr(0, 52, f(22));
        dreq = 2'b11;
        wait_done(0);
        wait_idle();
        dreq = 2'b00;
        chk("rr_c_done", 32'(done), 3);

        // source wraps FE,FF,00; fixed destination
        setup(1, 'hFE, 'h70, 3, 3);
        push_rd(1, 'hFE); push_wr(1, 'h70, f('hFE));
        push_rd(1, 'hFF); push_wr(1, 'h70, f('hFF));
        push_rd(1, 'h00); push_wr(1, 'h70, f('h00));
        dreq = 2'b10;
        wait_done(1);
        wait_idle();
        dreq = 2'b00;
        chk("wrap_mem", 32'(mem['h70]), 32'(f(0)));

        // HLDA lost during WRITE of byte 2
        setup(0, 'h80, 'h90, 3, 7);
        push_rd(0, 'h80); push_wr(0, 'h90, f('h80));
        push_rd(0, 'h81);
        push_rd(0, 'h81); push_wr(0, 'h91, f('h81));
        push_rd(0, 'h82); push_wr(0, 'h92, f('h82));
        dreq = 2'b01;
        wait_bus(4'b1010, 'h81);
        @(posedge clock);
        #1 drop = 1'b1;
        @(negedge clock);
        chk("drop_oe", 32'({AB_oe, DB_oe, CB_oe}), 0);
        chk("drop_hldr", 32'(HLDR), 1);
        repeat (2) @(negedge clock);
        drop = 1'b0;
        wait_done(0);
        wait_idle();
        dreq = 2'b00;
        for (int i = 0; i < 3; i++)
            chk("drop_mem", 32'(mem['h90 + i]), 32'(f('h80 + i)));
        chk("drop_cnt", 32'(dut.cnt[0]), 0);

        // dreq falls after first byte of four
        setup(0, 'hA0, 'hB0, 4, 7);
        push_rd(0, 'hA0); push_wr(0, 'hB0, f('hA0));
        dreq = 2'b01;
        wait_bus(4'b1001, 'hB0);
        dreq = 2'b00;
        wait_idle();
        chk("pause_cnt", 32'(dut.cnt[0]), 3);
        chk("pause_done", 32'(done[0]), 0);
        for (int i = 1; i < 4; i++) begin
            push_rd(0, 'hA0 + i);
            push_wr(0, 'hB0 + i, f('hA0 + i));
        end
        dreq = 2'b01;
        wait_done(0);
        wait_idle();
        dreq = 2'b00;
        chk("resume_mem", 32'(mem['hB3]), 32'(f('hA3)));

        // locked CTRL write, then reset inside WRITE
        setup(0, 'hC0, 'hD0, 3, 7);
        push_rd(0, 'hC0); push_wr(0, 'hD0, f('hC0));
        push_rd(0, 'hC1); push_wr(0, 'hD1, f('hC1));
        dreq = 2'b01;
        wait_bus(4'b1001, 'hD0);
        cfg_we = 1'b1; cfg_ch = 1'b0; cfg_reg = 2'd3; cfg_wdata = 8'h00;
        @(negedge clock);
        cfg_we = 1'b0;
        wait_bus(4'b1001, 'hD1);
        reset = 1'b1;
        @(negedge clock);
        chk("mrst_hldr", 32'(HLDR), 0);
        chk("mrst_oe", 32'({AB_oe, DB_oe, CB_oe}), 0);
        chk("mrst_dack", 32'(dack), 0);
        chk("mrst_regs", {dut.src[0], dut.dst[0], dut.cnt[0],
                          5'h0, dut.ctrl[0]}, 0);
        reset = 1'b0;
        dreq = 2'b00;
        wait_idle();
        chk("queue_empty", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
